dmem_arbiter: RTL

Two-port arbiter that shares the single-ported data memory (12-bit word address, 32-bit data, 1-cycle synchronous read latency) between the processor load/store path (port 0) and a secondary requester such as a boot loader or debug engine (port 1). Each port uses a req/ack handshake. The arbiter picks a winner, drives the memory for exactly one issue cycle, and returns ack with read data one cycle later. It sits between `processor`/loader and `dmem` in the top-level skeleton.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arbiter_rr_pick2.sv | 27 ++
 rtl/dmem_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Port 0 is the processor load/store path, port 1 the loader/debug requester.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way winner select for dmem_arbiter.
// Define DMEM_ARB_FIXED_PRIORITY_EN for fixed priority (port 0 wins ties); default is round-robin.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_owner,
  output logic o_valid,
  output logic o_grant
);

  assign o_valid = i_req0 | i_req1;

`ifdef DMEM_ARB_FIXED_PRIORITY_EN
  logic w_unused_last_owner;

  // The processor port always wins; history is irrelevant in this mode.
  assign w_unused_last_owner = i_last_owner;
  assign o_grant = (i_req0) ? PORT_CPU : (i_req1 ? PORT_AUX : PORT_CPU);
`else
  // On a tie the port that was not served last wins.
  assign o_grant = (i_req0 && i_req1) ? ~i_last_owner
                 : (i_req1 ? PORT_AUX : PORT_CPU);
`endif

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// Shares a single-ported, 1-cycle-latency data memory between two req/ack ports.
// Winner policy is set by DMEM_ARB_FIXED_PRIORITY_EN inside rr_pick2 (undefined = round-robin).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = dmem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = dmem_arb_pkg::DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              owner
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_req_valid;
  logic              w_grant;
  logic              w_take;

  rr_pick2 u_pick (
    .i_req0       (req0),
    .i_req1       (req1),
    .i_last_owner (r_owner),
    .o_valid      (w_req_valid),
    .o_grant      (w_grant)
  );

  assign w_take = (r_state == IDLE) && w_req_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_req_valid) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE; requesters may change them afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner <= PORT_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_owner <= w_grant;
      r_we    <= (w_grant == PORT_AUX) ? we1    : we0;
      r_addr  <= (w_grant == PORT_AUX) ? addr1  : addr0;
      r_wdata <= (w_grant == PORT_AUX) ? wdata1 : wdata0;
    end
  end

  // Outputs decode only from state and latched fields, never from live inputs.
  always_comb begin
    busy     = (r_state != IDLE);
    owner    = r_owner;
    mem_addr = r_addr;
    mem_data = r_wdata;
    mem_wren = (r_state == ISSUE) && r_we;
    ack0     = (r_state == RESP) && (r_owner == PORT_CPU);
    ack1     = (r_state == RESP) && (r_owner == PORT_AUX);
    rdata0   = ack0 ? mem_q : '0;
    rdata1   = ack1 ? mem_q : '0;
  end

endmodule : dmem_arbiter
